jtag_dr_ir_chain: RTL and testbench

- Instruction-register and data-register chain that sits directly downstream of the TAP controller state machine, in the tck domain.
- Consumes the TAP's current state plus TDI, and implements the 4-bit IR and the DR set: BYPASS, IDCODE and one USER register.
- Drives TDO (serial out) and presents decoded IR side-effects (user-register update, abort) to the rest of the design.

---
 rtl/jtag_dr_ir_chain.sv | 147 ++++++++++++++
 tb/tb_jtag_dr_ir_chain.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_ir_chain.sv
// JTAG instruction register plus BYPASS/IDCODE/USER data registers, driven by
// the TAP controller's current state in the tck domain.
module jtag_dr_ir_chain #(
    parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
    parameter int unsigned USER_WIDTH   = 8,
    parameter logic [3:0]  IR_CAPTURE   = 4'b0101
) (
    input  logic                  tck,
    input  logic                  trst_n,
    input  logic [4:0]            tap_state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [3:0]            ir_value,
    input  logic [USER_WIDTH-1:0] user_dr_in,
    output logic [USER_WIDTH-1:0] user_dr_out,
    output logic                  user_dr_update,
    output logic                  abort_pulse
);

    localparam int unsigned IR_W     = 4;
    localparam int unsigned DR_W     = 32;
    localparam int unsigned USER_MSB = USER_WIDTH - 1;

    localparam logic [4:0] TS_TLR    = 5'h00;
    localparam logic [4:0] TS_CAP_DR = 5'h04;
    localparam logic [4:0] TS_CAP_IR = 5'h05;
    localparam logic [4:0] TS_SH_DR  = 5'h06;
    localparam logic [4:0] TS_SH_IR  = 5'h07;
    localparam logic [4:0] TS_UPD_DR = 5'h0E;
    localparam logic [4:0] TS_UPD_IR = 5'h0F;

    localparam logic [IR_W-1:0] IR_ABORT  = 4'b1000;
    localparam logic [IR_W-1:0] IR_USER   = 4'b1010;
    localparam logic [IR_W-1:0] IR_IDCODE = 4'b1110;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    logic [IR_W-1:0]       ir_shift_q, ir_shift_d;
    logic [IR_W-1:0]       ir_value_q, ir_value_d;
    logic [DR_W-1:0]       dr_shift_q, dr_shift_d;
    logic [USER_WIDTH-1:0] user_dr_out_q, user_dr_out_d;
    logic                  user_dr_update_q, user_dr_update_d;
    logic                  abort_pulse_q, abort_pulse_d;
    dr_sel_e               dr_sel;
    logic [DR_W-1:0]       dr_shifted;

    // Any instruction other than IDCODE/USER routes the DR scan through BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value_q == IR_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_value_q == IR_USER) begin
            dr_sel = DR_USER;
        end
    end

    always_comb begin
        ir_shift_d       = ir_shift_q;
        ir_value_d       = ir_value_q;
        dr_shift_d       = dr_shift_q;
        user_dr_out_d    = user_dr_out_q;
        user_dr_update_d = 1'b0;
        abort_pulse_d    = 1'b0;
        dr_shifted       = {1'b0, dr_shift_q[DR_W-1:1]};

        case (tap_state)
            TS_TLR: begin
                ir_value_d = IR_IDCODE;
            end
            TS_CAP_IR: begin
                ir_shift_d = IR_CAPTURE;
            end
            TS_SH_IR: begin
                ir_shift_d = {tdi, ir_shift_q[IR_W-1:1]};
            end
            TS_UPD_IR: begin
                ir_value_d    = ir_shift_q;
                abort_pulse_d = (ir_shift_q == IR_ABORT);
            end
            TS_CAP_DR: begin
                case (dr_sel)
                    DR_IDCODE: dr_shift_d    = IDCODE_VALUE;
                    DR_USER:   dr_shift_d    = DR_W'(user_dr_in);
                    default:   dr_shift_d[0] = 1'b0;
                endcase
            end
            TS_SH_DR: begin
                // tdi enters at the top of the selected register's length
                dr_shift_d = dr_shifted;
                case (dr_sel)
                    DR_IDCODE: dr_shift_d[DR_W-1]   = tdi;
                    DR_USER:   dr_shift_d[USER_MSB] = tdi;
                    default:   dr_shift_d[0]        = tdi;
                endcase
            end
            TS_UPD_DR: begin
                if (dr_sel == DR_USER) begin
                    user_dr_out_d    = dr_shift_q[USER_WIDTH-1:0];
                    user_dr_update_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_shift_q       <= '0;
            ir_value_q       <= IR_IDCODE;
            dr_shift_q       <= '0;
            user_dr_out_q    <= '0;
            user_dr_update_q <= 1'b0;
            abort_pulse_q    <= 1'b0;
        end else begin
            ir_shift_q       <= ir_shift_d;
            ir_value_q       <= ir_value_d;
            dr_shift_q       <= dr_shift_d;
            user_dr_out_q    <= user_dr_out_d;
            user_dr_update_q <= user_dr_update_d;
            abort_pulse_q    <= abort_pulse_d;
        end
    end

    // Serial output is valid in the shift state ahead of the shifting edge.
    always_comb begin
        tdo    = 1'b0;
        tdo_oe = 1'b0;
        if (tap_state == TS_SH_IR) begin
            tdo    = ir_shift_q[0];
            tdo_oe = 1'b1;
        end else if (tap_state == TS_SH_DR) begin
            tdo    = dr_shift_q[0];
            tdo_oe = 1'b1;
        end
    end

    assign ir_value       = ir_value_q;
    assign user_dr_out    = user_dr_out_q;
    assign user_dr_update = user_dr_update_q;
    assign abort_pulse    = abort_pulse_q;

endmodule

// File: tb/tb_jtag_dr_ir_chain.sv
// Bench for jtag_dr_ir_chain: directed scans from the test plan, then a random
// legal TAP walk, all checked against a queue-based model of the registers.
module tb_jtag_dr_ir_chain;

    localparam logic [31:0] IDV = 32'h000FAF01;
    localparam int          UW  = 8;
    localparam logic [3:0]  IRC = 4'b0101;

    localparam logic [4:0] TLR = 5'h00, RTI = 5'h01, SELDR = 5'h02, SELIR = 5'h03;
    localparam logic [4:0] CAPDR = 5'h04, CAPIR = 5'h05, SHDR = 5'h06, SHIR = 5'h07;
    localparam logic [4:0] EX1DR = 5'h08, EX1IR = 5'h09, PAUDR = 5'h0A, PAUIR = 5'h0B;
    localparam logic [4:0] EX2DR = 5'h0C, EX2IR = 5'h0D, UPDDR = 5'h0E, UPDIR = 5'h0F;

    localparam logic [3:0] I_ABORT = 4'b1000, I_USER = 4'b1010;
    localparam logic [3:0] I_IDCODE = 4'b1110, I_BYPASS = 4'b1111;

    logic          tck, trst_n, tdi, tdo, tdo_oe;
    logic [4:0]    tap_state;
    logic [3:0]    ir_value;
    logic [UW-1:0] user_dr_in, user_dr_out;
    logic          user_dr_update, abort_pulse;

    jtag_dr_ir_chain #(
        .IDCODE_VALUE(IDV),
        .USER_WIDTH  (UW),
        .IR_CAPTURE  (IRC)
    ) dut (
        .tck           (tck),
        .trst_n        (trst_n),
        .tap_state     (tap_state),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_oe        (tdo_oe),
        .ir_value      (ir_value),
        .user_dr_in    (user_dr_in),
        .user_dr_out   (user_dr_out),
        .user_dr_update(user_dr_update),
        .abort_pulse   (abort_pulse)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as bit queues, front = bit 0 (next out on tdo).
    logic [3:0]    m_ir;
    bit            irq[$];
    bit            drq[$];
    logic [UW-1:0] m_uout;
    logic          m_uupd, m_abort;
    bit            m_valid = 1'b0;

    function automatic int dr_len(input logic [3:0] ir);
        if (ir == I_IDCODE) return 32;
        if (ir == I_USER) return UW;
        return 1;
    endfunction

    always @(posedge tck) begin
        if (!trst_n) begin
            m_valid = 1'b1;
            m_ir    = I_IDCODE;
            irq.delete();
            for (int i = 0; i < 4; i++) irq.push_back(1'b0);
            drq.delete();
            for (int i = 0; i < dr_len(I_IDCODE); i++) drq.push_back(1'b0);
            m_uout  = '0;
            m_uupd  = 1'b0;
            m_abort = 1'b0;
        end else if (m_valid) begin
            m_uupd  = 1'b0;
            m_abort = 1'b0;
            case (tap_state)
                TLR: m_ir = I_IDCODE;
                CAPIR: begin
                    irq.delete();
                    for (int i = 0; i < 4; i++) irq.push_back(IRC[i]);
                end
                SHIR: begin
                    void'(irq.pop_front());
                    irq.push_back(tdi);
                end
                UPDIR: begin
                    for (int i = 0; i < 4; i++) m_ir[i] = irq[i];
                    m_abort = (m_ir == I_ABORT);
                end
                CAPDR: begin
                    drq.delete();
                    if (m_ir == I_IDCODE) begin
                        for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
                    end else if (m_ir == I_USER) begin
                        for (int i = 0; i < UW; i++) drq.push_back(user_dr_in[i]);
                    end else begin
                        drq.push_back(1'b0);
                    end
                end
                SHDR: begin
                    void'(drq.pop_front());
                    drq.push_back(tdi);
                end
                UPDDR: begin
                    if (m_ir == I_USER) begin
                        for (int i = 0; i < UW; i++) m_uout[i] = drq[i];
                        m_uupd = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge tck) begin
        logic exp_tdo;
        if (m_valid) begin
            exp_tdo = 1'b0;
            if (tap_state == SHIR) exp_tdo = irq[0];
            else if (tap_state == SHDR) exp_tdo = drq[0];
            chk("tdo", 32'(tdo), 32'(exp_tdo));
            chk("tdo_oe", 32'(tdo_oe), 32'((tap_state == SHIR) || (tap_state == SHDR)));
            chk("ir_value", 32'(ir_value), 32'(m_ir));
            chk("user_dr_out", 32'(user_dr_out), 32'(m_uout));
            chk("user_dr_update", 32'(user_dr_update), 32'(m_uupd));
            chk("abort_pulse", 32'(abort_pulse), 32'(m_abort));
        end
    end

    task automatic step(input logic [4:0] st, input logic t, output logic o);
        tap_state = st;
        tdi       = t;
        @(negedge tck);
        o = tdo;
        @(posedge tck);
        #1;
    endtask

    // From RTI: load an instruction, stopping right after Update-IR.
    task automatic load_ir(input logic [3:0] code, output logic [3:0] cap);
        logic o;
        step(SELDR, 1'b0, o);
        step(SELIR, 1'b0, o);
        step(CAPIR, 1'b0, o);
        for (int i = 0; i < 4; i++) begin
            step(SHIR, code[i], o);
            cap[i] = o;
        end
        step(EX1IR, 1'b0, o);
        step(UPDIR, 1'b0, o);
    endtask

    // From RTI: full DR scan of n bits, stopping right after Update-DR.
    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic o;
        dout = '0;
        step(SELDR, 1'b0, o);
        step(CAPDR, 1'b0, o);
        for (int i = 0; i < n; i++) begin
            step(SHDR, din[i], o);
            dout[i] = o;
        end
        step(EX1DR, 1'b0, o);
        step(UPDDR, 1'b0, o);
    endtask

    function automatic logic [4:0] tap_next(input logic [4:0] s, input logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDDR : PAUDR;
            PAUDR:   return tms ? EX2DR : PAUDR;
            EX2DR:   return tms ? UPDDR : SHDR;
            UPDDR:   return tms ? SELDR : RTI;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPDIR : PAUIR;
            PAUIR:   return tms ? EX2IR : PAUIR;
            EX2IR:   return tms ? UPDIR : SHIR;
            UPDIR:   return tms ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    initial begin
        logic        o, tms;
        logic [31:0] v;
        logic [3:0]  c, tgt;
        logic [4:0]  ws;
        int          sh_i;

        trst_n     = 1'b0;
        tap_state  = TLR;
        tdi        = 1'b0;
        user_dr_in = '0;
        tgt        = '0;
        sh_i       = 0;
        repeat (2) @(posedge tck);
        #1;
        chk("rst_ir_value", 32'(ir_value), 32'h0000000E);
        chk("rst_user_dr_out", 32'(user_dr_out), 32'h0);
        chk("rst_update", 32'(user_dr_update), 32'h0);
        chk("rst_abort", 32'(abort_pulse), 32'h0);
        trst_n = 1'b1;

        // IDCODE read out LSB first
        step(RTI, 1'b0, o);
        dr_scan(32, 32'h0, v);
        chk("idcode_scan", v, 32'h000FAF01);
        chk("idcode_no_update", 32'(user_dr_update), 32'h0);
        step(RTI, 1'b0, o);

        // BYPASS via 1111, capture pattern seen on tdo, one-bit delay
        load_ir(4'b1111, c);
        chk("ir_capture_tdo", 32'(c), 32'h5);
        chk("ir_bypass", 32'(ir_value), 32'hF);
        step(RTI, 1'b0, o);
        dr_scan(3, 32'b101, v);
        chk("bypass_delay", v, 32'b010);
        step(RTI, 1'b0, o);

        // USER register exchange
        load_ir(4'b1010, c);
        step(RTI, 1'b0, o);
        user_dr_in = 8'hA5;
        dr_scan(8, 32'h3C, v);
        chk("user_capture_tdo", v, 32'hA5);
        chk("user_update_pulse", 32'(user_dr_update), 32'h1);
        chk("user_dr_out", 32'(user_dr_out), 32'h3C);
        step(RTI, 1'b0, o);
        chk("user_update_clear", 32'(user_dr_update), 32'h0);

        // ABORT pulse, then bypass behaviour
        load_ir(4'b1000, c);
        chk("abort_pulse_hi", 32'(abort_pulse), 32'h1);
        chk("ir_abort", 32'(ir_value), 32'h8);
        step(RTI, 1'b0, o);
        chk("abort_pulse_lo", 32'(abort_pulse), 32'h0);
        dr_scan(3, 32'b011, v);
        chk("abort_bypass", v, 32'b110);
        step(RTI, 1'b0, o);

        // Reset in the middle of an IDCODE shift
        load_ir(4'b1010, c);
        step(TLR, 1'b0, o);
        step(RTI, 1'b0, o);
        step(SELDR, 1'b0, o);
        step(CAPDR, 1'b0, o);
        v = '0;
        for (int i = 0; i < 16; i++) begin
            step(SHDR, 1'b1, o);
            v[i] = o;
        end
        chk("idcode_low_half", v, 32'h0000AF01);
        trst_n = 1'b0;
        step(SHDR, 1'b1, o);
        trst_n = 1'b1;
        chk("midrst_ir", 32'(ir_value), 32'hE);
        chk("midrst_update", 32'(user_dr_update), 32'h0);
        v = '1;
        for (int i = 0; i < 32; i++) begin
            step(SHDR, 1'b0, o);
            v[i] = o;
        end
        chk("midrst_dr_zero", v, 32'h0);
        step(TLR, 1'b0, o);

        // Pause in the middle of an IDCODE shift
        step(RTI, 1'b0, o);
        step(SELDR, 1'b0, o);
        step(CAPDR, 1'b0, o);
        v = '0;
        for (int i = 0; i < 4; i++) begin
            step(SHDR, 1'b0, o);
            v[i] = o;
        end
        step(EX1DR, 1'b0, o);
        repeat (5) step(PAUDR, 1'b0, o);
        step(EX2DR, 1'b0, o);
        for (int i = 4; i < 32; i++) begin
            step(SHDR, 1'b0, o);
            v[i] = o;
        end
        chk("pause_resume", v, 32'h000FAF01);
        step(EX1DR, 1'b0, o);
        step(UPDDR, 1'b0, o);
        step(RTI, 1'b0, o);

        // Random legal TAP walk with occasional resets and undefined states
        ws = RTI;
        for (int n = 0; n < 3000; n++) begin
            user_dr_in = UW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                trst_n    = 1'b0;
                tap_state = 5'($urandom);
                tdi       = 1'($urandom);
                @(posedge tck);
                #1;
                trst_n = 1'b1;
                ws     = TLR;
                continue;
            end
            if ($urandom_range(0, 39) == 0) begin
                tap_state = 5'($urandom_range(16, 31));
                tdi       = 1'($urandom);
                @(posedge tck);
                #1;
                continue;
            end
            tap_state = ws;
            if (ws == CAPIR) begin
                case ($urandom_range(0, 4))
                    0:       tgt = I_ABORT;
                    1:       tgt = I_USER;
                    2:       tgt = I_IDCODE;
                    3:       tgt = I_BYPASS;
                    default: tgt = 4'($urandom);
                endcase
                sh_i = 0;
            end
            if (ws == SHIR) begin
                tdi  = tgt[sh_i % 4];
                sh_i++;
            end else begin
                tdi = 1'($urandom);
            end
            if (ws == SHDR || ws == SHIR || ws == PAUDR || ws == PAUIR) begin
                tms = ($urandom_range(0, 9) < 2);
            end else begin
                tms = ($urandom_range(0, 9) < 4);
            end
            @(posedge tck);
            #1;
            ws = tap_next(ws, tms);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
